// File: rtl/capture_sequencer.sv
// Sequences TX prime, BIDIR loopback, RX drain via DMA and RX re-arm for N captures.
// Outputs are registered from the next state, so they track the state register with no extra lag.
module capture_sequencer #(
    parameter int TO_W  = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_captures,
    input  logic [TO_W-1:0]  timeout_cycles,
    input  logic             tx_ready,
    input  logic             rx_full,
    input  logic             rx_empty,
    output logic             txfifo_rd_en,
    output logic             mck_en,
    output logic             chan_start,
    output logic             rx_drain_en,
    output logic             dma_out_en,
    output logic             rx_rearm,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] cap_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_REARM = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t          cur;
    state_t          nxt;
    logic [TO_W-1:0] to_cnt;
    logic            tmo;

    assign tmo   = (timeout_cycles != '0) && (to_cnt == timeout_cycles - TO_W'(1));
    assign state = cur;

    // Priority: abort, then the state's own exit condition, then timeout.
    always_comb begin
        nxt = cur;
        if (abort) begin
            nxt = S_IDLE;
        end else begin
            case (cur)
                S_IDLE:  if (start) nxt = S_PRIME;
                S_PRIME: if (tx_ready) nxt = S_RUN;
                         else if (tmo) nxt = S_ERR;
                S_RUN:   if (rx_full) nxt = S_DRAIN;
                         else if (tmo) nxt = S_ERR;
                S_DRAIN: if (rx_empty && !rx_full) nxt = S_REARM;
                         else if (tmo) nxt = S_ERR;
                S_REARM: if ((num_captures != '0) && (cap_count == num_captures)) nxt = S_DONE;
                         else nxt = S_RUN;
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur          <= S_IDLE;
            to_cnt       <= '0;
            cap_count    <= '0;
            error        <= 1'b0;
            txfifo_rd_en <= 1'b0;
            mck_en       <= 1'b0;
            chan_start   <= 1'b0;
            rx_drain_en  <= 1'b0;
            dma_out_en   <= 1'b0;
            rx_rearm     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            cur <= nxt;

            if (nxt != cur)
                to_cnt <= '0;
            else if (cur == S_PRIME || cur == S_RUN || cur == S_DRAIN)
                to_cnt <= to_cnt + TO_W'(1);

            // The increment lands on REARM entry so the REARM cycle compares the new count.
            if (cur == S_IDLE && nxt == S_PRIME)
                cap_count <= '0;
            else if (nxt == S_REARM)
                cap_count <= cap_count + CNT_W'(1);

            if (cur == S_IDLE && nxt == S_PRIME)
                error <= 1'b0;
            else if (nxt == S_ERR)
                error <= 1'b1;

            txfifo_rd_en <= (nxt == S_PRIME) || (nxt == S_RUN);
            mck_en       <= (nxt == S_RUN) || (nxt == S_DRAIN) || (nxt == S_REARM);
            chan_start   <= (nxt == S_RUN) || (nxt == S_DRAIN) || (nxt == S_REARM);
            rx_drain_en  <= (nxt == S_DRAIN);
            dma_out_en   <= (nxt == S_DRAIN);
            rx_rearm     <= (nxt == S_REARM);
            busy         <= (nxt != S_IDLE);
            done         <= (nxt == S_DONE);
        end
    end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Hardware sequencer for the TX-FIFO → BIDIR loopback → RX-FIFO → DMA capture loop. It replaces the CPU-driven register sequence: prime TX, start BIDIR out/in channels, wait for RX FIFO full/halt, drain it through the DMA output path, then re-arm. It repeats for a programmed number of captures. It sits beside the AXI-Lite register blocks and drives their enable bits directly.

## Interface
Parameters:
- TO_W, 24, width of the per-phase timeout counter
- CNT_W, 8, width of the capture count and counter

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  single-cycle request to begin a sequence; ignored while busy
- abort  in  1  level; forces return to IDLE
- num_captures  in  CNT_W  captures per sequence; 0 = run until abort
- timeout_cycles  in  TO_W  per-phase timeout limit; 0 = timeout disabled
- tx_ready  in  1  TX FIFO filled (TXFIFO fill-done flag)
- rx_full  in  1  RX FIFO full/halted flag (RXFIFO_REG3 bit 31)
- rx_empty  in  1  RX FIFO empty flag (RXFIFO_REG3 bit 30)
- txfifo_rd_en  out  1  TX FIFO read enable (TXFIFO_REG0[0] equivalent)
- mck_en  out  1  BIDIR MCK/output enable (BIDIR_REG2[0])
- chan_start  out  1  BIDIR out+in channel start (BIDIR_REG1[0] and [4])
- rx_drain_en  out  1  RX FIFO read/drain enable (RXFIFO_REG0[0])
- dma_out_en  out  1  DMA output enable (DMA_REG1[0])
- rx_rearm  out  1  one-cycle pulse that clears the RX halt (RXFIFO_REG1[0])
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sequence completes
- error  out  1  sticky timeout flag; cleared by the next accepted start or by reset
- cap_count  out  CNT_W  completed captures in the current sequence
- state  out  3  encoded state, for the status register

## Operation
- States: IDLE=0, PRIME=1, RUN=2, DRAIN=3, REARM=4, DONE=5, ERR=6.
- IDLE:
  - start=1 → PRIME.
  - Accepting start clears cap_count and error.
- PRIME:
  - txfifo_rd_en=1.
  - tx_ready=1 → RUN.
- RUN:
  - txfifo_rd_en=1, mck_en=1, chan_start=1.
  - rx_full=1 → DRAIN.
- DRAIN:
  - mck_en=1, chan_start=1, rx_drain_en=1, dma_out_en=1.
  - rx_empty=1 and rx_full=0 → REARM.
- REARM:
  - Lasts exactly one cycle; rx_rearm=1 and cap_count increments (wraps at 2^CNT_W).
  - If num_captures≠0 and the incremented count equals num_captures → DONE; else → RUN.
- DONE: one cycle, done=1, then → IDLE. cap_count holds its value.
- ERR: error=1 (sticky). All enables are 0 and busy=1 for one cycle, then → IDLE.
- Timeout:
  - A counter clears on every state entry and increments each cycle in PRIME, RUN and DRAIN.
  - When timeout_cycles≠0 and the counter reaches timeout_cycles−1 with no transition that cycle → ERR.
  - If the exit condition and the timeout coincide, the exit condition wins.
- Abort:
  - abort=1 in any non-IDLE state → IDLE next cycle; all enables drop; no done pulse.
  - Abort has priority over every other transition.
  - start and abort high together in IDLE → remain in IDLE.
- Outputs not listed for a state are 0 in that state.

## Timing
- State, counters and all outputs are registered.
- Outputs reflect the current state register: a condition sampled at edge N changes the outputs from edge N+1.
- Reset (resetn=0 at a rising edge):
  - state=IDLE.
  - All enables, rx_rearm, done, busy and error = 0.
  - cap_count=0; timeout counter = 0.
  - Reset mid-sequence behaves identically and produces no pulses.
- Latencies:
  - start → txfifo_rd_en/busy: 1 cycle.
  - rx_full → rx_drain_en/dma_out_en: 1 cycle.
  - rx_empty → rx_rearm pulse: 1 cycle.
  - Last rearm → done: 1 cycle.
- txfifo_rd_en deasserts on DRAIN entry and reasserts on return to RUN.
- mck_en and chan_start stay high continuously across RUN→DRAIN→REARM→RUN.
- rx_rearm and done are always exactly one cycle wide.

## Test plan
- Single capture:
  - Stimulus: num_captures=1, timeout=0; start; tx_ready at +10 cycles; rx_full at +100; rx_full=0 and rx_empty=1 at +200.
  - Required: states 1→2→3→4→5→0; rx_rearm and done each pulse once; cap_count=1; error=0.
- Multiple captures:
  - Stimulus: num_captures=3 with the same rx_full/rx_empty handshake repeated three times.
  - Required: three rx_rearm pulses; PRIME entered only once; done follows the third rearm; cap_count=3.
- Timeout:
  - Stimulus: timeout_cycles=50; tx_ready held at 0.
  - Required: ERR on cycle 50 after PRIME entry; error=1 stays set after return to IDLE; the next start clears it.
- Abort:
  - Stimulus: assert abort in DRAIN.
  - Required: the next cycle is IDLE with all enables 0, no done and no rx_rearm. A start while busy (in RUN) is ignored.
- Continuous and reset:
  - Stimulus: num_captures=0 through 300 capture handshakes.
  - Required: cap_count wraps 255→0 (hence 300→44); no done. Then resetn=0 for one cycle mid-RUN → all outputs 0 and state=0 on the following cycle.
